// File: rtl/dm_cache_if.sv
// dm_cache_if: processor request/response and backing-memory command bundle for dm_cache.
interface dm_cache_if #(parameter int DATA_W = 16, parameter int ADDR_W = 16);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_hit;
  logic              mem_rd;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;
  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, mem_rdata, mem_ack,
    output req_ready, resp_valid, resp_rdata, resp_hit, mem_rd, mem_wr, mem_addr, mem_wdata
  );
  modport master (
    output req_valid, req_we, req_addr, req_wdata, mem_rdata, mem_ack,
    input  req_ready, resp_valid, resp_rdata, resp_hit, mem_rd, mem_wr, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dm_cache.sv
// dm_cache: direct-mapped, write-through no-allocate cache with word-serial line refill.
// Define CACHE_STATS_EN to add saturating read hit/miss counters.
module dm_cache #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 16,
  parameter int INDEX_W  = 6,
  parameter int OFFSET_W = 2
) (
  input logic clk_100,
  input logic rst_n,
  dm_cache_if.slave bus
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);
  localparam int TAG_W = ADDR_W - INDEX_W - OFFSET_W;
  localparam int LINES = 2 ** INDEX_W;
  localparam int WORDS = 2 ** OFFSET_W;
  typedef enum logic [2:0] {IDLE, LOOKUP, FILL, WRITE, RESP} state_t;
  state_t state, state_nx;
  logic [ADDR_W-1:0]   addr;
  logic                we;
  logic [DATA_W-1:0]   wdata;
  logic [OFFSET_W-1:0] k;
  logic [LINES-1:0]    valid;
  logic [TAG_W-1:0]    tags [LINES];
  logic [DATA_W-1:0]   data [LINES*WORDS];
  logic [TAG_W-1:0]    tag_a;
  logic [INDEX_W-1:0]  idx;
  logic [OFFSET_W-1:0] off;
  logic                hit, last;
  assign tag_a = addr[ADDR_W-1 -: TAG_W];
  assign idx   = addr[OFFSET_W +: INDEX_W];
  assign off   = addr[OFFSET_W-1:0];
  assign hit   = valid[idx] && tags[idx] == tag_a;
  assign last  = &k;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = bus.req_valid ? LOOKUP : IDLE;
      LOOKUP:  state_nx = we ? WRITE : hit ? RESP : FILL;
      FILL:    state_nx = (bus.mem_ack && last) ? RESP : FILL;
      WRITE:   state_nx = bus.mem_ack ? RESP : WRITE;
      default: state_nx = IDLE;
    endcase
  end
  always_comb begin
    bus.req_ready  = state == IDLE;
    bus.resp_valid = state == RESP;
    bus.mem_rd     = state == FILL;
    bus.mem_wr     = state == WRITE;
    bus.mem_addr   = (state == FILL) ? {tag_a, idx, k} : (state == WRITE) ? addr : '0;
    bus.mem_wdata  = (state == WRITE) ? wdata : '0;
  end
  always_ff @(posedge clk_100 or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      addr           <= '0;
      we             <= 1'b0;
      wdata          <= '0;
      k              <= '0;
      valid          <= '0;
      bus.resp_hit   <= 1'b0;
      bus.resp_rdata <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && bus.req_valid) begin
        addr  <= bus.req_addr;
        we    <= bus.req_we;
        wdata <= bus.req_wdata;
      end
      if (state == LOOKUP) begin
        bus.resp_hit <= hit;
        k            <= '0;
        if (!we && hit) bus.resp_rdata <= data[{idx, off}];
      end
      if (state == FILL && bus.mem_ack) begin
        k <= k + 1'b1;
        // the final word is not in the array yet, so take it straight from memory
        if (last) begin
          valid[idx]     <= 1'b1;
          bus.resp_rdata <= (off == k) ? bus.mem_rdata : data[{idx, off}];
        end
      end
    end
  end
  always_ff @(posedge clk_100) begin
    if (state == LOOKUP && we && hit) data[{idx, off}] <= wdata;
    if (state == FILL && bus.mem_ack) data[{idx, k}] <= bus.mem_rdata;
    if (state == FILL && bus.mem_ack && last) tags[idx] <= tag_a;
  end
`ifdef CACHE_STATS_EN
  always_ff @(posedge clk_100 or negedge rst_n) begin
    if (!rst_n) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (state == LOOKUP && !we) begin
      if (hit && !(&hit_count)) hit_count <= hit_count + 32'd1;
      if (!hit && !(&miss_count)) miss_count <= miss_count + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_dm_cache.sv
// tb_dm_cache: directed scoreboard bench for dm_cache with a memory model answering commands.
module tb_dm_cache;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  dm_cache_if #(.DATA_W(16), .ADDR_W(16)) bus ();
`ifdef CACHE_STATS_EN
  logic [31:0] hit_count, miss_count;
  dm_cache dut (.clk_100(clk), .rst_n(rst_n), .bus(bus), .hit_count(hit_count), .miss_count(miss_count));
`else
  dm_cache dut (.clk_100(clk), .rst_n(rst_n), .bus(bus));
`endif
  typedef struct {logic hit; logic [15:0] rdata; int lat;} resp_t;
  typedef struct {logic wr; logic [15:0] addr; logic [15:0] wdata;} mop_t;
  resp_t resp_q[$];
  mop_t  mem_q[$];
  logic [15:0] mem_arr [bit [15:0]];
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int acc_cyc = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask
  always @(posedge clk) cyc++;
  // response monitor: every completion pulse must match the oldest expectation
  always @(negedge clk) begin
    resp_t e;
    if (rst_n && bus.resp_valid) begin
      if (resp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_resp actual=%0h required=none", bus.resp_rdata);
      end else begin
        e = resp_q.pop_front();
        chk("resp_hit", {31'd0, bus.resp_hit}, {31'd0, e.hit});
        chk("resp_rdata", {16'd0, bus.resp_rdata}, {16'd0, e.rdata});
        if (e.lat > 0) chk("resp_latency", cyc - acc_cyc, e.lat);
      end
    end
  end
  // memory model: acks every other cycle, checks each command against the expected list
  always @(negedge clk) begin
    mop_t e;
    if (!rst_n || bus.mem_ack) bus.mem_ack = 1'b0;
    else if (bus.mem_rd || bus.mem_wr) begin
      chk("mem_excl", {31'd0, bus.mem_rd & bus.mem_wr}, 32'd0);
      if (mem_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_mem actual=%0h required=none", bus.mem_addr);
      end else begin
        e = mem_q.pop_front();
        chk("mem_wr", {31'd0, bus.mem_wr}, {31'd0, e.wr});
        chk("mem_addr", {16'd0, bus.mem_addr}, {16'd0, e.addr});
        if (e.wr) chk("mem_wdata", {16'd0, bus.mem_wdata}, {16'd0, e.wdata});
      end
      if (bus.mem_wr) mem_arr[bus.mem_addr] = bus.mem_wdata;
      bus.mem_rdata = mem_arr.exists(bus.mem_addr) ? mem_arr[bus.mem_addr]
                    : ((bus.mem_addr[14] ? 16'hB000 : 16'hA000) + {14'd0, bus.mem_addr[1:0]});
      bus.mem_ack = 1'b1;
    end
  end
  task automatic exp_resp(input logic h, input logic [15:0] d, input int lat);
    resp_t r;
    r.hit = h; r.rdata = d; r.lat = lat;
    resp_q.push_back(r);
  endtask
  task automatic exp_mem(input logic w, input logic [15:0] a, input logic [15:0] d);
    mop_t m;
    m.wr = w; m.addr = a; m.wdata = d;
    mem_q.push_back(m);
  endtask
  task automatic exp_fill(input logic [15:0] a, input int n);
    for (int i = 0; i < n; i++) exp_mem(1'b0, {a[15:2], 2'(i)}, 16'h0);
  endtask
  task automatic issue(input logic w, input logic [15:0] a, input logic [15:0] d);
    int n = 0;
    @(negedge clk);
    while (!bus.req_ready && n < 50) begin @(negedge clk); n++; end
    if (n == 50) begin
      checks++;
      failures++;
      $display("FAIL req_ready_timeout actual=0 required=1");
    end
    bus.req_valid = 1'b1; bus.req_we = w; bus.req_addr = a; bus.req_wdata = d;
    acc_cyc = cyc;
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask
  task automatic drain();
    int n = 0;
    while ((resp_q.size() != 0 || mem_q.size() != 0) && n < 200) begin @(negedge clk); n++; end
    chk("drain", resp_q.size() + mem_q.size(), 0);
  endtask
  initial begin
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
    bus.mem_ack = 1'b0; bus.mem_rdata = '0;
    #22;
    chk("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
    chk("rst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
    chk("rst_resp_hit", {31'd0, bus.resp_hit}, 32'd0);
    chk("rst_mem_cmd", {30'd0, bus.mem_rd, bus.mem_wr}, 32'd0);
    chk("rst_resp_rdata", {16'd0, bus.resp_rdata}, 32'd0);
    chk("rst_mem_addr", {16'd0, bus.mem_addr}, 32'd0);
    chk("rst_mem_wdata", {16'd0, bus.mem_wdata}, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    exp_fill(16'h1234, 4); exp_resp(1'b0, 16'hA000, 0); issue(1'b0, 16'h1234, 16'h0); drain();
    exp_resp(1'b1, 16'hA001, 2); issue(1'b0, 16'h1235, 16'h0); drain();
    exp_mem(1'b1, 16'h1236, 16'hBEEF); exp_resp(1'b1, 16'hA001, 0); issue(1'b1, 16'h1236, 16'hBEEF); drain();
    exp_resp(1'b1, 16'hBEEF, 2); issue(1'b0, 16'h1236, 16'h0); drain();
`ifdef CACHE_STATS_EN
    chk("hit_count", hit_count, 32'd2);
    chk("miss_count", miss_count, 32'd1);
`endif
    exp_fill(16'h5634, 4); exp_resp(1'b0, 16'hB000, 0); issue(1'b0, 16'h5634, 16'h0); drain();
    exp_fill(16'h1234, 4); exp_resp(1'b0, 16'hA000, 0); issue(1'b0, 16'h1234, 16'h0); drain();
    exp_resp(1'b1, 16'hBEEF, 2); issue(1'b0, 16'h1236, 16'h0); drain();
    exp_mem(1'b1, 16'h0100, 16'h1111); exp_resp(1'b0, 16'hBEEF, 0); issue(1'b1, 16'h0100, 16'h1111); drain();
    exp_fill(16'h0100, 4); exp_resp(1'b0, 16'h1111, 0); issue(1'b0, 16'h0100, 16'h0); drain();
    exp_fill(16'h2340, 2); issue(1'b0, 16'h2340, 16'h0);
    for (int n = 0; n < 100 && mem_q.size() != 0; n++) @(negedge clk);
    chk("fill_two_acks", mem_q.size(), 0);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_req_ready", {31'd0, bus.req_ready}, 32'd1);
    chk("midrst_mem_rd", {31'd0, bus.mem_rd}, 32'd0);
    chk("midrst_resp_rdata", {16'd0, bus.resp_rdata}, 32'd0);
    @(negedge clk);
    @(negedge clk) rst_n = 1'b1;
    exp_fill(16'h2340, 4); exp_resp(1'b0, 16'hA000, 0); issue(1'b0, 16'h2340, 16'h0); drain();
    exp_fill(16'h1235, 4); exp_resp(1'b0, 16'hA001, 0); issue(1'b0, 16'h1235, 16'h0); drain();
    repeat (4) @(negedge clk);
    chk("idle_ready", {31'd0, bus.req_ready}, 32'd1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end
endmodule
